// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire sweep: one neuron per cycle per timestep,
// spikes leave as neuron-ID events on a valid/ready port that can stall the sweep.
module lif_sweep_scheduler #(
   parameter int NUM_NEURONS = 4,
   parameter int ID_W        = 2,
   parameter int V_W         = 8,
   parameter int LEAK_SHIFT  = 3,
   parameter int REFRAC      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   in_we,
   input  logic [ID_W-1:0]        in_addr,
   input  logic [V_W-1:0]         in_data,
   input  logic [V_W-1:0]         thresh,
   output logic                   busy,
   output logic                   done,
   output logic                   spike_valid,
   input  logic                   spike_ready,
   output logic [ID_W-1:0]        spike_id,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic [3:0]             overrun
);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_EMIT, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ID_W-1:0]       r_idx;
   logic [V_W-1:0]        r_v      [NUM_NEURONS];
   logic [3:0]            r_refrac [NUM_NEURONS];
   logic [V_W-1:0]        r_cur    [NUM_NEURONS];
   logic [ID_W-1:0]       r_spike_id;
   logic [NUM_NEURONS-1:0] r_spike_vec;
   logic [3:0]            r_overrun;

   logic [V_W-1:0]        w_v_now;
   logic [V_W-1:0]        w_leaked;
   logic [V_W:0]          w_sum_wide;
   logic [V_W-1:0]        w_sum;
   logic                  w_in_refrac;
   logic                  w_fire;
   logic                  w_last;

   always_comb begin
      w_v_now     = r_v[r_idx];
      w_leaked    = w_v_now - (w_v_now >> LEAK_SHIFT);
      w_sum_wide  = {1'b0, w_leaked} + {1'b0, r_cur[r_idx]};
      w_sum       = w_sum_wide[V_W] ? {V_W{1'b1}} : w_sum_wide[V_W-1:0];
      w_in_refrac = (r_refrac[r_idx] != 4'd0);
      w_fire      = !w_in_refrac && (thresh != {V_W{1'b0}}) && (w_sum >= thresh);
      w_last      = (r_idx == ID_W'(NUM_NEURONS - 1));
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   w_next_state = tick ? S_UPDATE : S_IDLE;
         S_UPDATE: begin
            if (w_fire)      w_next_state = S_EMIT;
            else if (w_last) w_next_state = S_DONE;
            else             w_next_state = S_UPDATE;
         end
         S_EMIT: begin
            if (spike_ready) w_next_state = w_last ? S_DONE : S_UPDATE;
            else             w_next_state = S_EMIT;
         end
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Sweep datapath: index, membrane and refractory files, spike bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= {ID_W{1'b0}};
         r_spike_id  <= {ID_W{1'b0}};
         r_spike_vec <= {NUM_NEURONS{1'b0}};
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_v[i]      <= {V_W{1'b0}};
            r_refrac[i] <= 4'd0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (tick) begin
                  r_idx       <= {ID_W{1'b0}};
                  r_spike_vec <= {NUM_NEURONS{1'b0}};
               end
            end
            S_UPDATE: begin
               if (w_in_refrac) begin
                  r_v[r_idx]      <= {V_W{1'b0}};
                  r_refrac[r_idx] <= r_refrac[r_idx] - 4'd1;
               end else if (w_fire) begin
                  r_v[r_idx]         <= {V_W{1'b0}};
                  r_refrac[r_idx]    <= 4'(REFRAC);
                  r_spike_vec[r_idx] <= 1'b1;
                  r_spike_id         <= r_idx;
               end else begin
                  r_v[r_idx] <= w_sum;
               end
               if (!w_fire && !w_last) r_idx <= r_idx + ID_W'(1);
            end
            S_EMIT: begin
               if (spike_ready && !w_last) r_idx <= r_idx + ID_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Host current writes land in any state; an update in the same cycle sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) r_cur[i] <= {V_W{1'b0}};
      end else if (in_we) begin
         r_cur[in_addr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                               r_overrun <= 4'd0;
      else if (tick && r_state != S_IDLE && r_overrun != 4'd15) r_overrun <= r_overrun + 4'd1;
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign spike_valid = (r_state == S_EMIT);
   assign spike_id    = r_spike_id;
   assign spike_vec   = r_spike_vec;
   assign overrun     = r_overrun;

endmodule
